// File: rtl/led_pkg.sv
// Shared types and defaults for the LED breathing stage.
package led_pkg;

    typedef enum logic [1:0] {
        PH_UP   = 2'd0,
        PH_HI   = 2'd1,
        PH_DOWN = 2'd2,
        PH_LO   = 2'd3
    } phase_t;

    localparam int DEF_PWM_BITS         = 8;
    localparam int DEF_PERIODS_PER_STEP = 4;
    localparam int DEF_HOLD_STEPS       = 8;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_breather_if.sv
// Enable input and observable outputs of the breathing LED stage.
interface led_breather_if #(parameter int PWM_BITS = led_pkg::DEF_PWM_BITS);

    logic                EN;
    logic                LED;
    logic [PWM_BITS-1:0] DUTY;
    logic [1:0]          PHASE;
    logic                CYCLE_DONE;

    modport master (output EN, input LED, DUTY, PHASE, CYCLE_DONE);
    modport slave  (input EN, output LED, DUTY, PHASE, CYCLE_DONE);

endinterface

// File: rtl/led_step_timer.sv
// Free-running PWM counter plus a divider that strobes once every
// PERIODS_PER_STEP PWM periods.
module led_step_timer
    import led_pkg::*;
#(
    parameter int PWM_BITS         = DEF_PWM_BITS,
    parameter int PERIODS_PER_STEP = DEF_PERIODS_PER_STEP
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                step
);

    localparam int                  SW        = cnt_width(PERIODS_PER_STEP);
    localparam logic [PWM_BITS-1:0] DMAX      = '1;
    localparam logic [SW-1:0]       STEP_LAST = SW'(PERIODS_PER_STEP - 1);

    logic [SW-1:0] step_cnt;
    logic          period_end;

    assign period_end = EN && (pwm_cnt == DMAX);
    assign step       = period_end && (step_cnt == STEP_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            pwm_cnt  <= '0;
            step_cnt <= '0;
        end else if (EN) begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (period_end)
                step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_breather.sv
// Breathing PWM LED driver: ramps duty up, holds, ramps down, holds, repeats.
module led_breather
    import led_pkg::*;
#(
    parameter int PWM_BITS         = DEF_PWM_BITS,
    parameter int PERIODS_PER_STEP = DEF_PERIODS_PER_STEP,
    parameter int HOLD_STEPS       = DEF_HOLD_STEPS
) (
    input  logic          CLK,
    input  logic          RST,
    led_breather_if.slave bus
);

    localparam int                  HW        = cnt_width(HOLD_STEPS);
    localparam logic [PWM_BITS-1:0] DMAX      = '1;
    localparam logic [PWM_BITS-1:0] DMAX_M1   = DMAX - 1'b1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
    localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_STEPS - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                step;
    logic [PWM_BITS-1:0] duty;
    logic [HW-1:0]       hold_cnt;
    phase_t              phase;
    logic                led;
    logic                cycle_done;

    led_step_timer #(
        .PWM_BITS        (PWM_BITS),
        .PERIODS_PER_STEP(PERIODS_PER_STEP)
    ) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (bus.EN),
        .pwm_cnt(pwm_cnt),
        .step   (step)
    );

    // Duty only moves on step strobes, which land on period ends, so a
    // PWM period never sees two different duty values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase      <= PH_UP;
            duty       <= '0;
            hold_cnt   <= '0;
            led        <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            led        <= bus.EN && (pwm_cnt < duty);
            cycle_done <= 1'b0;
            if (step) begin
                unique case (phase)
                    PH_UP: begin
                        duty <= duty + 1'b1;
                        if (duty == DMAX_M1) begin
                            phase    <= PH_HI;
                            hold_cnt <= '0;
                        end
                    end
                    PH_HI: begin
                        if (hold_cnt == HOLD_LAST) begin
                            phase    <= PH_DOWN;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    PH_DOWN: begin
                        duty <= duty - 1'b1;
                        if (duty == DUTY_ONE) begin
                            phase    <= PH_LO;
                            hold_cnt <= '0;
                        end
                    end
                    PH_LO: begin
                        if (hold_cnt == HOLD_LAST) begin
                            phase      <= PH_UP;
                            hold_cnt   <= '0;
                            cycle_done <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.LED        = led;
    assign bus.DUTY       = duty;
    assign bus.PHASE      = phase;
    assign bus.CYCLE_DONE = cycle_done;

endmodule

// File: doc/led_breather.md
Name: led_breather

Overview:
Downstream LED output stage that turns the board LED from a hard on/off blink into a "breathing" PWM fade.
- A free-running PWM counter is compared against a duty register.
- A 4-phase FSM ramps the duty up, holds it high, ramps it down, then holds it low, and repeats.
- The block drives the user LED pin directly.
- EN gates it, and EN is normally tied to the blink output of the counter-based blinker, so that blinker's output now enables breathing.

Parameters:
PWM_BITS, 8, width of the PWM counter and duty register; DMAX = 2^PWM_BITS-1
PERIODS_PER_STEP, 4, PWM periods per duty step (>=1)
HOLD_STEPS, 8, steps spent in each hold phase (>=1)

Ports:
CLK  input  1  system clock, all logic on the rising edge
RST  input  1  synchronous, active-high reset
EN  input  1  run enable; 0 freezes all state and forces LED low
LED  output  1  registered PWM output to the LED pin
DUTY  output  PWM_BITS  current duty register
PHASE  output  2  FSM state: 0=UP, 1=HI, 2=DOWN, 3=LO
CYCLE_DONE  output  1  one-cycle pulse at the end of each full breath

Behaviour:
- Clock and reset: one clock, CLK; reset RST is synchronous and active-high. No asynchronous logic.
- Reset values: pwm_cnt=0, step_cnt=0, hold_cnt=0, DUTY=0, PHASE=UP, LED=0, CYCLE_DONE=0.
- RST asserted mid-breath: all state returns to the reset values on the next edge. Nothing is retained.
- pwm_cnt: increments every cycle while EN=1 and wraps from DMAX to 0. A period is 2^PWM_BITS cycles.
- LED: registered, one-cycle latency. LED <= EN & (pwm_cnt < DUTY).
  - DUTY=0 gives LED always 0.
  - DUTY=DMAX gives LED high for DMAX of every 2^PWM_BITS cycles.
- Period end: pwm_cnt==DMAX with EN=1.
  - At a period end, step_cnt increments and wraps at PERIODS_PER_STEP-1.
  - A step event occurs at a period end where step_cnt==PERIODS_PER_STEP-1.
- DUTY and PHASE change only on step events, so there are no mid-period duty glitches.
- FSM actions on a step event:
  - UP: DUTY <= DUTY+1. If DUTY+1==DMAX, go to HI and clear hold_cnt.
  - HI: hold_cnt++. When hold_cnt==HOLD_STEPS-1, go to DOWN and clear hold_cnt. DUTY stays at DMAX.
  - DOWN: DUTY <= DUTY-1. If DUTY-1==0, go to LO and clear hold_cnt.
  - LO: hold_cnt++. When hold_cnt==HOLD_STEPS-1, go to UP, clear hold_cnt, and set CYCLE_DONE=1 for exactly the next cycle.
- DUTY never wraps. It stays within 0..DMAX by construction, with no saturating arithmetic needed.
- One breath = 2*DMAX + 2*HOLD_STEPS step events.
- EN=0:
  - pwm_cnt, step_cnt, hold_cnt, DUTY and PHASE hold their values.
  - LED goes to 0 on the next edge.
  - No step event and no CYCLE_DONE can occur.
  - When EN returns to 1, operation resumes from the frozen point; the step in progress is not restarted.
- EN toggled on the cycle where pwm_cnt==DMAX: with EN=0 no step occurs. The step fires at the next period end taken with EN=1.
- RST and EN both high: RST wins.

Decomposition:
- Shared package led_pkg holds:
  - the phase encoding (PH_UP=0, PH_HI=1, PH_DOWN=2, PH_LO=3) as a 2-bit typedef;
  - the default constants for PWM_BITS, PERIODS_PER_STEP and HOLD_STEPS.
- One sub-module, led_step_timer, contains pwm_cnt and step_cnt.
  - Inputs: CLK, RST, EN.
  - Outputs: pwm_cnt and a step-event strobe.
- The FSM, DUTY and the LED comparator stay in led_breather.

Test Plan (PWM_BITS=4, PERIODS_PER_STEP=1, HOLD_STEPS=2 unless stated; DMAX=15, period=16 cycles, breath=34 steps=544 cycles):
1. Reset, then hold EN=1 -> LED=0 for the first 16 cycles (DUTY=0). The first step event is on the cycle where pwm_cnt==15, 16 cycles after RST release, and DUTY becomes 1. In the next period LED is high for exactly 1 cycle, one cycle after pwm_cnt==0.
2. Run a full breath -> PHASE sequence UP(15 steps), HI(2), DOWN(15), LO(2). DUTY peaks at 15 and returns to 0. CYCLE_DONE pulses once, for 1 cycle, 544 cycles after RST release, then every 544 cycles.
3. During HI (DUTY=15) -> LED is high 15 of every 16 cycles. During LO -> LED is never high.
4. Drop EN for 50 cycles mid-UP at DUTY=7 -> LED=0 from the next edge. DUTY, PHASE and pwm_cnt are frozen. After EN is restored, DUTY reaches 8 exactly at the next period end taken with EN=1, and the total breath length grows by exactly 50 cycles.
5. Assert RST for 1 cycle during DOWN at DUTY=9 -> next cycle DUTY=0, PHASE=UP, LED=0, pwm_cnt=0. No CYCLE_DONE is produced.
6. PWM_BITS=8, PERIODS_PER_STEP=4, HOLD_STEPS=8 -> a step every 1024 cycles. CYCLE_DONE period = 526 steps * 1024 cycles = 538624 cycles.
